// File: rtl/otter_mem_port2_arbiter.sv
// Port-2 arbiter for the OTTER dual-port memory: CPU load/store unit vs. debug/program loader.
// Optional misalignment check enabled by defining OTTER_ARB_ALIGN_CHK_EN.
module otter_mem_port2_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        MEM_CLK,
    input  logic        MEM_RST_N,

    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [31:0] CPU_ADDR,
    input  logic [31:0] CPU_DIN,
    input  logic [1:0]  CPU_SIZE,
    input  logic        CPU_SIGN,
    output logic        CPU_GNT,
    output logic        CPU_RVALID,
    output logic [31:0] CPU_DOUT,

    input  logic        DBG_REQ,
    input  logic        DBG_WE,
    input  logic [31:0] DBG_ADDR,
    input  logic [31:0] DBG_DIN,
    input  logic [1:0]  DBG_SIZE,
    input  logic        DBG_SIGN,
    output logic        DBG_GNT,
    output logic        DBG_RVALID,
    output logic [31:0] DBG_DOUT,

    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic        MEM_READ2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2,

    output logic        ERR
);

    localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic              owner_q, owner_d;  // 1 = debug loader owns the active request
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0]       cpu_dout_q, cpu_dout_d;
    logic [31:0]       dbg_dout_q, dbg_dout_d;

    logic              dbg_win;
    logic              misaligned;
    logic [31:0]       rd_data;

`ifdef OTTER_ARB_ALIGN_CHK_EN
    assign misaligned = ((size_q == 2'd1) && addr_q[0]) ||
                        ((size_q == 2'd2) && (addr_q[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign dbg_win = DBG_REQ && (!CPU_REQ || (cnt_q == Limit));
    assign rd_data = misaligned ? 32'h0 : MEM_DOUT2;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        din_d        = din_q;
        we_d         = we_q;
        size_d       = size_q;
        sign_d       = sign_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        cpu_dout_d   = cpu_dout_q;
        dbg_dout_d   = dbg_dout_q;

        if (!DBG_REQ) begin
            cnt_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (CPU_REQ || DBG_REQ) begin
                    state_d = StAccess;
                    owner_d = dbg_win;
                    if (dbg_win) begin
                        addr_d = DBG_ADDR;
                        din_d  = DBG_DIN;
                        we_d   = DBG_WE;
                        size_d = DBG_SIZE;
                        sign_d = DBG_SIGN;
                        cnt_d  = '0;
                    end else begin
                        addr_d = CPU_ADDR;
                        din_d  = CPU_DIN;
                        we_d   = CPU_WE;
                        size_d = CPU_SIZE;
                        sign_d = CPU_SIGN;
                        if (DBG_REQ && (cnt_q != Limit)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            StAccess: begin
                state_d = we_q ? StIdle : StResp;
            end
            StResp: begin
                // Memory read data is registered, so it is valid during this cycle.
                state_d = StIdle;
                if (owner_q) begin
                    dbg_dout_d   = rd_data;
                    dbg_rvalid_d = 1'b1;
                end else begin
                    cpu_dout_d   = rd_data;
                    cpu_rvalid_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            din_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            sign_q       <= 1'b0;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_dout_q   <= '0;
            dbg_dout_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_dout_q   <= cpu_dout_d;
            dbg_dout_q   <= dbg_dout_d;
        end
    end

    always_comb begin
        CPU_GNT    = (state_q == StAccess) && !owner_q;
        DBG_GNT    = (state_q == StAccess) && owner_q;
        CPU_RVALID = cpu_rvalid_q;
        DBG_RVALID = dbg_rvalid_q;
        CPU_DOUT   = cpu_dout_q;
        DBG_DOUT   = dbg_dout_q;
        MEM_ADDR2  = addr_q;
        MEM_DIN2   = din_q;
        MEM_SIZE   = size_q;
        MEM_SIGN   = sign_q;
        MEM_WRITE2 = (state_q == StAccess) && we_q && !misaligned;
        MEM_READ2  = (state_q == StAccess) && !we_q && !misaligned;
        ERR        = (state_q == StAccess) && misaligned;
    end

endmodule

// File: tb/tb_otter_mem_port2_arbiter.sv
// Directed bench for otter_mem_port2_arbiter with a small byte-addressed memory behind port 2.
module tb_otter_mem_port2_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 0, cpu_we = 0, cpu_sign = 0;
    logic [31:0] cpu_addr = 0, cpu_din = 0;
    logic [1:0]  cpu_size = 0;
    logic        dbg_req = 0, dbg_we = 0, dbg_sign = 0;
    logic [31:0] dbg_addr = 0, dbg_din = 0;
    logic [1:0]  dbg_size = 0;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_dout, dbg_dout;
    logic [31:0] mem_addr2, mem_din2;
    logic        mem_write2, mem_read2, mem_sign, err;
    logic [1:0]  mem_size;
    logic [31:0] mem_dout2 = 0;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] mem [0:1023];

    always #5 clk = ~clk;

    otter_mem_port2_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .MEM_CLK    (clk),
        .MEM_RST_N  (rst_n),
        .CPU_REQ    (cpu_req),
        .CPU_WE     (cpu_we),
        .CPU_ADDR   (cpu_addr),
        .CPU_DIN    (cpu_din),
        .CPU_SIZE   (cpu_size),
        .CPU_SIGN   (cpu_sign),
        .CPU_GNT    (cpu_gnt),
        .CPU_RVALID (cpu_rvalid),
        .CPU_DOUT   (cpu_dout),
        .DBG_REQ    (dbg_req),
        .DBG_WE     (dbg_we),
        .DBG_ADDR   (dbg_addr),
        .DBG_DIN    (dbg_din),
        .DBG_SIZE   (dbg_size),
        .DBG_SIGN   (dbg_sign),
        .DBG_GNT    (dbg_gnt),
        .DBG_RVALID (dbg_rvalid),
        .DBG_DOUT   (dbg_dout),
        .MEM_ADDR2  (mem_addr2),
        .MEM_DIN2   (mem_din2),
        .MEM_WRITE2 (mem_write2),
        .MEM_READ2  (mem_read2),
        .MEM_SIZE   (mem_size),
        .MEM_SIGN   (mem_sign),
        .MEM_DOUT2  (mem_dout2),
        .ERR        (err)
    );

    function automatic logic [31:0] mem_rd(input logic [9:0] a, input logic [1:0] sz,
                                           input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = mem[a];
        h = {mem[a + 10'd1], mem[a]};
        case (sz)
            2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return {mem[a + 10'd3], mem[a + 10'd2], h};
        endcase
    endfunction

    // Port-2 memory: writes commit at the edge, reads are registered.
    always @(posedge clk) begin
        if (mem_write2) begin
            mem[mem_addr2[9:0]] = mem_din2[7:0];
            if (mem_size != 2'd0) mem[mem_addr2[9:0] + 10'd1] = mem_din2[15:8];
            if (mem_size == 2'd2) begin
                mem[mem_addr2[9:0] + 10'd2] = mem_din2[23:16];
                mem[mem_addr2[9:0] + 10'd3] = mem_din2[31:24];
            end
        end
        if (mem_read2) mem_dout2 <= mem_rd(mem_addr2[9:0], mem_size, mem_sign);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic sg);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; cpu_size = sz; cpu_sign = sg;
    endtask

    task automatic dbg_set(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic sg);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_din = d; dbg_size = sz; dbg_sign = sg;
    endtask

    logic [1:0] exp_g [6];
    logic       seen;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        exp_g = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

        // Reset
        cycle(); cycle();
        check("rst_cpu_gnt", {31'h0, cpu_gnt}, 0);
        check("rst_dbg_gnt", {31'h0, dbg_gnt}, 0);
        check("rst_rvalid", {30'h0, cpu_rvalid, dbg_rvalid}, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_dbg_dout", dbg_dout, 0);
        check("rst_mem_addr", mem_addr2, 0);
        check("rst_mem_din", mem_din2, 0);
        check("rst_mem_ctl", {27'h0, mem_write2, mem_read2, mem_size, mem_sign}, 0);
        check("rst_err", {31'h0, err}, 0);
        rst_n = 1'b1;
        cycle();

        // CPU sw 0x100
        cpu_set(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0);
        cycle();
        check("sw_gnt", {30'h0, cpu_gnt, dbg_gnt}, 32'h2);
        check("sw_wr_rd", {30'h0, mem_write2, mem_read2}, 32'h2);
        check("sw_addr", mem_addr2, 32'h100);
        check("sw_din", mem_din2, 32'hDEADBEEF);
        check("sw_err", {31'h0, err}, 0);
        cpu_req = 1'b0;
        cycle();
        check("sw_idle_gnt", {31'h0, cpu_gnt}, 0);
        check("sw_idle_wr", {31'h0, mem_write2}, 0);
        check("sw_addr_hold", mem_addr2, 32'h100);

        // CPU lw 0x100
        cpu_set(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        cycle();
        check("lw_gnt", {31'h0, cpu_gnt}, 1);
        check("lw_rd", {30'h0, mem_write2, mem_read2}, 32'h1);
        cpu_req = 1'b0;
        cycle();
        check("lw_resp_rvalid", {31'h0, cpu_rvalid}, 0);
        cycle();
        check("lw_rvalid", {31'h0, cpu_rvalid}, 1);
        check("lw_dout", cpu_dout, 32'hDEADBEEF);
        cycle();
        check("lw_rvalid_pulse", {31'h0, cpu_rvalid}, 0);
        check("lw_dout_hold", cpu_dout, 32'hDEADBEEF);

        // DBG byte write 0x203 while CPU idle
        dbg_set(1'b1, 32'h203, 32'h000000A5, 2'd0, 1'b0);
        cycle();
        check("dbg_sb_gnt", {30'h0, cpu_gnt, dbg_gnt}, 32'h1);
        check("dbg_sb_size", {30'h0, mem_size}, 0);
        dbg_req = 1'b0;
        cycle();

        // CPU lbu 0x203
        cpu_set(1'b0, 32'h203, 32'h0, 2'd0, 1'b1);
        cycle();
        cpu_req = 1'b0;
        cycle(); cycle();
        check("lbu_rvalid", {31'h0, cpu_rvalid}, 1);
        check("lbu_dout", cpu_dout, 32'h000000A5);

        // CPU lh (signed) 0x100 -> 0xBEEF sign-extended
        cpu_set(1'b0, 32'h100, 32'h0, 2'd1, 1'b0);
        cycle();
        cpu_req = 1'b0;
        cycle(); cycle();
        check("lh_dout", cpu_dout, 32'hFFFFBEEF);
        cycle();

        // Starvation: both requesting writes continuously
        cpu_set(1'b1, 32'h300, 32'h11112222, 2'd2, 1'b0);
        dbg_set(1'b1, 32'h304, 32'h5555AAAA, 2'd2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check($sformatf("starve_gnt%0d", i), {30'h0, cpu_gnt, dbg_gnt}, {30'h0, exp_g[i]});
            if (i == 5) begin
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
            cycle();
        end

        // Overlap: CPU request arrives during DBG read RESP
        dbg_set(1'b0, 32'h304, 32'h0, 2'd2, 1'b0);
        cycle();
        check("ov_dbg_gnt", {30'h0, cpu_gnt, dbg_gnt}, 32'h1);
        dbg_req = 1'b0;
        cycle();
        cpu_set(1'b0, 32'h300, 32'h0, 2'd2, 1'b0);
        check("ov_resp_no_gnt", {30'h0, cpu_gnt, dbg_gnt}, 0);
        cycle();
        check("ov_dbg_rvalid", {31'h0, dbg_rvalid}, 1);
        check("ov_dbg_dout", dbg_dout, 32'h5555AAAA);
        check("ov_idle_no_gnt", {31'h0, cpu_gnt}, 0);
        cycle();
        check("ov_cpu_gnt", {31'h0, cpu_gnt}, 1);
        check("ov_dbg_rvalid_off", {31'h0, dbg_rvalid}, 0);
        cpu_req = 1'b0;
        cycle(); cycle();
        check("ov_cpu_rvalid", {31'h0, cpu_rvalid}, 1);
        check("ov_cpu_dout", cpu_dout, 32'h11112222);
        check("ov_dbg_dout_hold", dbg_dout, 32'h5555AAAA);
        cycle();

        // Misaligned lw 0x102
        cpu_set(1'b0, 32'h102, 32'h0, 2'd2, 1'b0);
        cycle();
        cpu_req = 1'b0;
`ifdef OTTER_ARB_ALIGN_CHK_EN
        check("mis_err_gnt", {30'h0, err, cpu_gnt}, 32'h3);
        check("mis_rd", {31'h0, mem_read2}, 0);
        cycle(); cycle();
        check("mis_rvalid", {31'h0, cpu_rvalid}, 1);
        check("mis_dout", cpu_dout, 32'h0);
`else
        check("mis_err_gnt", {30'h0, err, cpu_gnt}, 32'h1);
        check("mis_rd", {31'h0, mem_read2}, 1);
        cycle(); cycle();
        check("mis_rvalid", {31'h0, cpu_rvalid}, 1);
        check("mis_dout", cpu_dout, 32'h0000DEAD);
`endif
        cycle();

        // Reset in the middle of ACCESS drops the read
        cpu_set(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        cycle();
        check("mr_gnt", {31'h0, cpu_gnt}, 1);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("mr_gnt_drop", {30'h0, cpu_gnt, mem_read2}, 0);
        cycle();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seen = seen | cpu_rvalid | cpu_gnt;
        end
        check("mr_no_rvalid", {31'h0, seen}, 0);
        check("mr_dout_cleared", cpu_dout, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
